// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the EXE-stage hazard/forwarding controller.
package exe_hazard_ctrl_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;
  localparam fwd_sel_t FWD_MEM  = 2'b01;
  localparam fwd_sel_t FWD_WB   = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/exe_hazard_ctrl_reg_match.sv
// One source/producer comparison: r0 never aliases because writes to it are discarded.
module reg_match
  import exe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_used,
  input  logic [4:0] i_dest,
  input  logic       i_wb_en,
  output logic       o_hit
);

  assign o_hit = i_used && i_wb_en && (i_src != REG_ZERO) && (i_src == i_dest);

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Hazard/forwarding control for EXE: registered forward selects, stall/bubble/flush, perf counters.
module exe_hazard_ctrl
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic             id_imm,
  input  logic [4:0]       exe_dest,
  input  logic [4:0]       mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_read,
  input  logic             br_taken,
  output logic [1:0]       val1_forward_sel,
  output logic [1:0]       val2_forward_sel,
  output logic [1:0]       val3_forward_sel,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       o_state
);

  // Operand order: val1 <- src1, val2 <- src2 unless immediate, val3 <- src2 (store data).
  logic [2:0] w_used;
  logic [4:0] w_src [3];
  logic [2:0] w_exe_hit;
  logic [2:0] w_mem_hit;

  assign w_used = {id_src2_used, id_src2_used & ~id_imm, id_src1_used};
  assign w_src[0] = id_src1;
  assign w_src[1] = id_src2;
  assign w_src[2] = id_src2;

  for (genvar g = 0; g < 3; g++) begin : g_match
    reg_match u_exe_match (
      .i_src  (w_src[g]),
      .i_used (w_used[g]),
      .i_dest (exe_dest),
      .i_wb_en(exe_wb_en),
      .o_hit  (w_exe_hit[g])
    );
    reg_match u_mem_match (
      .i_src  (w_src[g]),
      .i_used (w_used[g]),
      .i_dest (mem_dest),
      .i_wb_en(mem_wb_en),
      .o_hit  (w_mem_hit[g])
    );
  end

  logic w_hazard;
  logic w_stall;

  assign w_hazard = fwd_en ? (id_valid & exe_mem_read & (|w_exe_hit))
                           : (id_valid & ((|w_exe_hit) | (|w_mem_hit)));
  assign w_stall  = w_hazard & ~br_taken;

  assign stall  = w_stall;
  assign bubble = w_stall;
  assign flush  = br_taken;

  fwd_sel_t w_next_sel [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_next_sel[i] = FWD_NONE;
      if (fwd_en && !w_stall && !br_taken) begin
        if (w_exe_hit[i])      w_next_sel[i] = FWD_MEM;
        else if (w_mem_hit[i]) w_next_sel[i] = FWD_WB;
      end
    end
  end

  state_t w_next_state;

  always_comb begin
    w_next_state = ST_RUN;
    if (br_taken)      w_next_state = ST_FLUSH;
    else if (w_hazard) w_next_state = ST_STALL;
  end

  state_t           r_state;
  fwd_sel_t         r_sel [3];
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_sel[0]      <= FWD_NONE;
      r_sel[1]      <= FWD_NONE;
      r_sel[2]      <= FWD_NONE;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state  <= w_next_state;
      r_sel[0] <= w_next_sel[0];
      r_sel[1] <= w_next_sel[1];
      r_sel[2] <= w_next_sel[2];
      if (w_stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (br_taken && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign val1_forward_sel = r_sel[0];
  assign val2_forward_sel = r_sel[1];
  assign val3_forward_sel = r_sel[2];
  assign stall_count      = r_stall_count;
  assign flush_count      = r_flush_count;
  assign o_state          = r_state;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: directed pipeline scenarios plus random traffic against a reference model.
module tb_exe_hazard_ctrl;
  import exe_hazard_ctrl_pkg::*;

  localparam int CNT_W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             fwd_en = 1'b1;
  logic             id_valid = 1'b0;
  logic [4:0]       id_src1 = '0, id_src2 = '0;
  logic             id_src1_used = 1'b0, id_src2_used = 1'b0, id_imm = 1'b0;
  logic [4:0]       exe_dest = '0, mem_dest = '0;
  logic             exe_wb_en = 1'b0, mem_wb_en = 1'b0, exe_mem_read = 1'b0;
  logic             br_taken = 1'b0;
  logic [1:0]       val1_forward_sel, val2_forward_sel, val3_forward_sel;
  logic             stall, bubble, flush;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [1:0]       o_state;

  exe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_imm(id_imm),
    .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_read(exe_mem_read),
    .br_taken(br_taken),
    .val1_forward_sel(val1_forward_sel), .val2_forward_sel(val2_forward_sel),
    .val3_forward_sel(val3_forward_sel),
    .stall(stall), .bubble(bubble), .flush(flush),
    .stall_count(stall_count), .flush_count(flush_count), .o_state(o_state)
  );

  // scoreboard
  logic [5:0]       exp_q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] m_stall_cnt = '0;
  logic [CNT_W-1:0] m_flush_cnt = '0;
  logic [1:0]       m_state = ST_RUN;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [4:0] src, input logic used,
                               input logic [4:0] dest, input logic wb);
    return used && wb && (src != 5'd0) && (src == dest);
  endfunction

  function automatic logic [1:0] pick(input logic e, input logic m);
    if (e) return 2'b01;
    if (m) return 2'b10;
    return 2'b00;
  endfunction

  // Drive one cycle (called just after a rising edge), check comb outputs
  // mid-cycle, then check registered results after the next edge.
  task automatic step(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u1, input logic u2, input logic imm,
                      input logic [4:0] ed, input logic ewb, input logic eld,
                      input logic [4:0] md, input logic mwb, input logic br);
    logic e1, e2, e3, m1, m2, m3, hz, exp_stall;
    logic [5:0] nxt;
    id_valid = v; id_src1 = s1; id_src2 = s2; id_src1_used = u1; id_src2_used = u2;
    id_imm = imm; exe_dest = ed; exe_wb_en = ewb; exe_mem_read = eld;
    mem_dest = md; mem_wb_en = mwb; br_taken = br;
    @(negedge clk);
    e1 = hit(s1, u1, ed, ewb);  m1 = hit(s1, u1, md, mwb);
    e2 = hit(s2, u2 & ~imm, ed, ewb);  m2 = hit(s2, u2 & ~imm, md, mwb);
    e3 = hit(s2, u2, ed, ewb);  m3 = hit(s2, u2, md, mwb);
    hz = fwd_en ? (v & eld & (e1 | e2 | e3)) : (v & (e1 | e2 | e3 | m1 | m2 | m3));
    exp_stall = hz & ~br;
    check("stall", 32'(stall), 32'(exp_stall));
    check("bubble", 32'(bubble), 32'(exp_stall));
    check("flush", 32'(flush), 32'(br));
    if (br || exp_stall || !fwd_en) nxt = 6'b0;
    else nxt = {pick(e1, m1), pick(e2, m2), pick(e3, m3)};
    exp_q.push_back(nxt);
    if (exp_stall && m_stall_cnt != '1) m_stall_cnt++;
    if (br && m_flush_cnt != '1) m_flush_cnt++;
    m_state = br ? ST_FLUSH : (hz ? ST_STALL : ST_RUN);
    @(posedge clk); #1;
    check("sel", 32'({val1_forward_sel, val2_forward_sel, val3_forward_sel}), 32'(exp_q.pop_front()));
    check("stall_count", stall_count, m_stall_cnt);
    check("flush_count", flush_count, m_flush_cnt);
    check("state", 32'(o_state), 32'(m_state));
  endtask

  initial begin
    // reset state
    #12;
    check("rst_sel", 32'({val1_forward_sel, val2_forward_sel, val3_forward_sel}), 32'd0);
    check("rst_stall_count", stall_count, 32'd0);
    check("rst_flush_count", flush_count, 32'd0);
    check("rst_state", 32'(o_state), 32'(ST_RUN));
    check("rst_comb", 32'({stall, bubble, flush}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD r3 in EXE, SUB r4,r3,r5 in ID: forward from MEM, no stall
    fwd_en = 1'b1;
    step(1, 5'd3, 5'd5, 1, 1, 0, 5'd3, 1, 0, 5'd0, 0, 0);
    check("add_v1", 32'(val1_forward_sel), 32'(FWD_MEM));
    check("add_v2", 32'(val2_forward_sel), 32'(FWD_NONE));

    // LW r3 in EXE, ADD r4,r3,r3 in ID: one stall, then both from WB
    step(1, 5'd3, 5'd3, 1, 1, 0, 5'd3, 1, 1, 5'd0, 0, 0);
    check("lu_count", stall_count, 32'd1);
    step(1, 5'd3, 5'd3, 1, 1, 0, 5'd0, 0, 0, 5'd3, 1, 0);
    check("lu_v1", 32'(val1_forward_sel), 32'(FWD_WB));
    check("lu_v2", 32'(val2_forward_sel), 32'(FWD_WB));

    // SW r3,0(r1), r3 in MEM: store data from WB, val2 is the immediate
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd0, 0, 0, 5'd3, 1, 0);
    check("sw_v3", 32'(val3_forward_sel), 32'(FWD_WB));
    check("sw_v2", 32'(val2_forward_sel), 32'(FWD_NONE));

    // No forwarding: ADD r3 in EXE then ADD r5,r3,r0 -> two stalls
    fwd_en = 1'b0;
    step(1, 5'd3, 5'd0, 1, 1, 0, 5'd3, 1, 0, 5'd0, 0, 0);
    step(1, 5'd3, 5'd0, 1, 1, 0, 5'd0, 0, 0, 5'd3, 1, 0);
    step(1, 5'd3, 5'd0, 1, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    check("nofwd_count", stall_count, 32'd3);

    // Branch taken during load-use: flush wins
    fwd_en = 1'b1;
    step(1, 5'd3, 5'd3, 1, 1, 0, 5'd3, 1, 1, 5'd0, 0, 1);
    check("br_flush_count", flush_count, 32'd1);
    check("br_stall_count", stall_count, 32'd3);
    check("br_state", 32'(o_state), 32'(ST_FLUSH));
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    check("br_state_after", 32'(o_state), 32'(ST_RUN));

    // r0 producer and wb_en=0 producer never hit
    step(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 1, 1, 5'd0, 1, 0);
    step(1, 5'd7, 5'd7, 1, 1, 0, 5'd7, 0, 1, 5'd7, 0, 0);
    check("nohit_sel", 32'({val1_forward_sel, val2_forward_sel, val3_forward_sel}), 32'd0);

    // Asynchronous reset in the middle of a stall
    step(1, 5'd4, 5'd0, 1, 0, 0, 5'd4, 1, 0, 5'd0, 0, 0);
    id_valid = 1; id_src1 = 5'd4; id_src1_used = 1; exe_dest = 5'd4;
    exe_wb_en = 1; exe_mem_read = 1;
    @(negedge clk);
    check("mid_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", 32'({val1_forward_sel, val2_forward_sel, val3_forward_sel}), 32'd0);
    check("arst_stall_count", stall_count, 32'd0);
    check("arst_flush_count", flush_count, 32'd0);
    check("arst_state", 32'(o_state), 32'(ST_RUN));
    id_valid = 0;
    #1;
    check("arst_comb", 32'({stall, bubble, flush}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_stall_cnt = '0; m_flush_cnt = '0; m_state = ST_RUN;

    // Random traffic over a small register range to provoke collisions
    for (int i = 0; i < 300; i++) begin
      fwd_en = 1'($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
